lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller that executes the memory-access encoding produced by the main decoder, at the data-memory end of that control interface.
- Takes one request per transaction (lw, lbu, sw, sb) from the MEM stage and drives a single-port synchronous word RAM.
- Performs byte extraction for lbu and read-modify-write for sb, and returns the load data.
- Sits between the pipeline MEM stage and data memory; the hazard unit holds the pipeline while req_ready is low.

Parameters:
- ADDR_WIDTH, 32, width of the byte address from the ALU.
- MEM_AW, 10, word-address width of the data RAM; mem_addr = req_addr[MEM_AW+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  MEM-stage access request.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high.
- req_op  in  2  decoder MemWrite code: 00 lw, 10 lbu, 01 sw, 11 sb; bit0 = store, bit1 = byte.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; sb uses bits [7:0].
- rsp_valid  out  1  one-cycle pulse marking transaction completion.
- rsp_err  out  1  valid with rsp_valid; indicates a misaligned word access.
- rsp_rdata  out  32  load result, valid with rsp_valid for loads, 0 otherwise.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after a read command.

Behaviour:
- States: IDLE, RD, RESP, RMW_RD, MERGE, WR, ERR. Memory-side outputs are registered.
- Reset (rst==0 at an edge):
  - state returns to IDLE; mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err and rsp_rdata all become 0.
  - Any in-flight transaction is dropped, and no write is issued after the reset edge.
- Accept at cycle T (IDLE): latch op, addr and wdata.
- Misaligned word access (lw or sw with addr[1:0]!=0):
  - Goes to ERR; no mem_en is issued.
  - At T+1: rsp_valid=1, rsp_err=1, rsp_rdata=0. Then IDLE.
- lw:
  - RD at T+1 drives mem_en=1, mem_we=0.
  - RESP at T+2: rsp_valid=1, rsp_rdata=mem_rdata (combinational from the RAM port). Then IDLE.
- lbu:
  - Same timing as lw.
  - rsp_rdata = zero-extended mem_rdata byte at lane addr[1:0], little-endian (lane n = bits [8n+7:8n]).
- sw:
  - WR at T+1 drives mem_en=1, mem_we=1, mem_wdata=wdata.
  - rsp_valid=1 in the same cycle. Then IDLE.
- sb (default build, read-modify-write):
  - RMW_RD at T+1 issues the read.
  - MERGE at T+2 registers mem_rdata with lane addr[1:0] replaced by wdata[7:0]; other lanes are unchanged.
  - WR at T+3 writes the merged word; rsp_valid=1 at T+3.
- Latency: lw/lbu 2 cycles, sw 1 cycle, sb 3 cycles, error 1 cycle. req_ready is low from T+1 until the state returns to IDLE.
- req_valid while busy is ignored; the requester must hold the request.
- Simultaneous accept and reset: reset wins.
- Upper address bits above MEM_AW+1 are ignored, so addresses wrap within the RAM.
- mem_en and mem_we are 0 in IDLE, RESP, MERGE and ERR.
- rsp_rdata is 0 whenever rsp_valid is 0.

Optional Feature:
- Macro: LSU_BYTE_STROBE_EN.
- Defined:
  - Adds output port mem_be [3:0], one enable per byte lane.
  - sb skips RMW_RD and MERGE: WR at T+1 with mem_be = 1<<addr[1:0] and mem_wdata = wdata[7:0] replicated to all four lanes; rsp_valid at T+1.
  - Word writes use mem_be=4'b1111; mem_be is 0 in non-write cycles and at reset.
- Undefined: the port is absent and sb uses read-modify-write.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_t.
  - op constants OP_LW=2'b00, OP_SW=2'b01, OP_LBU=2'b10, OP_SB=2'b11, shared with the decoder.
  - byte-lane width constant.
- One sub-module, lsu_byte_lane: combinational lane extract (lbu) and lane merge (sb) keyed by addr[1:0].

Test Plan:
- Preload RAM word 4 = 32'hA1B2C3D4; lw addr 0x10 -> mem_en at T+1, rsp_valid at T+2, rsp_rdata=32'hA1B2C3D4, rsp_err=0.
- lbu addr 0x11, 0x12 and 0x13 on the same word -> rsp_rdata 32'h000000C3, 32'h000000B2, 32'h000000A1.
- sb wdata 32'hFFFFFF5A to addr 0x12 on the same word, then lw 0x10 -> 32'hA15AC3D4.
  - Default build: write at T+3.
  - With LSU_BYTE_STROBE_EN: write at T+1 with mem_be=4'b0100.
- sw 32'hDEADBEEF to 0x08, then lw 0x08 -> 32'hDEADBEEF. A back-to-back request is held until req_ready returns high.
- lw addr 0x06 -> rsp_valid=1, rsp_err=1 at T+1; mem_en stays 0.
- sb issued, rst=0 during MERGE -> next cycle all outputs 0, state IDLE, no write; RAM word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Op codes match the main decoder's MemWrite encoding: bit0 = store, bit1 = byte.
package lsu_pkg;

    localparam logic [1:0] OP_LW  = 2'b00;
    localparam logic [1:0] OP_SW  = 2'b01;
    localparam logic [1:0] OP_LBU = 2'b10;
    localparam logic [1:0] OP_SB  = 2'b11;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RESP,
        S_RMW_RD,
        S_MERGE,
        S_WR,
        S_ERR
    } lsu_state_t;

    // Word ops must be 4-byte aligned; byte ops never fault.
    function automatic logic is_misaligned(
        input logic [1:0] op,
        input logic [1:0] lo
    );
        return !op[1] && (lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: extract (lbu) and merge (sb) one little-endian lane.
// Ports: lane = addr[1:0], word = RAM word, wbyte = store byte; ext / merged out.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]                  lane,
    input  logic [NUM_LANES*LANE_W-1:0] word,
    input  logic [LANE_W-1:0]           wbyte,
    output logic [NUM_LANES*LANE_W-1:0] ext,
    output logic [NUM_LANES*LANE_W-1:0] merged
);

    always_comb begin
        ext                           = '0;
        merged                        = word;
        ext[LANE_W-1:0]               = word[lane*LANE_W +: LANE_W];
        merged[lane*LANE_W +: LANE_W] = wbyte;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a single-port sync word RAM.
// Ports: req_* (valid/ready request), rsp_* (completion pulse, err, load data),
// mem_* (registered RAM command), mem_rdata (RAM data, one cycle after read).
// Build option LSU_BYTE_STROBE_EN: adds mem_be and does sb as one strobed write.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
`ifdef LSU_BYTE_STROBE_EN
    output logic [3:0]            mem_be,
`endif
    input  logic [31:0]           mem_rdata
);

    lsu_state_t state_q, state_d;

    logic              byte_q;
    logic [1:0]        lane_q;
    logic [LANE_W-1:0] wbyte_q;

    logic              en_d, we_d;
    logic [MEM_AW-1:0] addr_d;
    logic [31:0]       wdata_d;
`ifdef LSU_BYTE_STROBE_EN
    logic [3:0]        be_d;
`endif

    logic [31:0] lane_ext, lane_merged;
    logic        accept;

    // Address bits above the RAM are intentionally dropped (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MEM_AW+2];

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    lsu_byte_lane u_lane (
        .lane   (lane_q),
        .word   (mem_rdata),
        .wbyte  (wbyte_q),
        .ext    (lane_ext),
        .merged (lane_merged)
    );

    // Load data is taken straight off the RAM port in RESP.
    always_comb begin
        rsp_rdata = '0;
        if (state_q == S_RESP)
            rsp_rdata = byte_q ? lane_ext : mem_rdata;
    end

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
`ifdef LSU_BYTE_STROBE_EN
        be_d    = 4'b0000;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_op, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else begin
                        addr_d = req_addr[MEM_AW+1:2];
                        case (req_op)
                            OP_LW, OP_LBU: begin
                                state_d = S_RD;
                                en_d    = 1'b1;
                            end
                            OP_SW: begin
                                state_d = S_WR;
                                en_d    = 1'b1;
                                we_d    = 1'b1;
                                wdata_d = req_wdata;
`ifdef LSU_BYTE_STROBE_EN
                                be_d    = 4'b1111;
`endif
                            end
                            OP_SB: begin
`ifdef LSU_BYTE_STROBE_EN
                                state_d = S_WR;
                                en_d    = 1'b1;
                                we_d    = 1'b1;
                                wdata_d = {NUM_LANES{req_wdata[7:0]}};
                                be_d    = 4'b0001 << req_addr[1:0];
`else
                                state_d = S_RMW_RD;
                                en_d    = 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_RD:     state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            S_RMW_RD: state_d = S_MERGE;
            S_MERGE: begin
                state_d = S_WR;
                en_d    = 1'b1;
                we_d    = 1'b1;
                wdata_d = lane_merged;
`ifdef LSU_BYTE_STROBE_EN
                be_d    = 4'b1111;
`endif
            end
            S_WR:     state_d = S_IDLE;
            S_ERR:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            byte_q    <= 1'b0;
            lane_q    <= 2'b00;
            wbyte_q   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
`ifdef LSU_BYTE_STROBE_EN
            mem_be    <= 4'b0000;
`endif
        end else begin
            state_q   <= state_d;
            mem_en    <= en_d;
            mem_we    <= we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            rsp_valid <= (state_d == S_RESP) || (state_d == S_WR) ||
                         (state_d == S_ERR);
            rsp_err   <= (state_d == S_ERR);
`ifdef LSU_BYTE_STROBE_EN
            mem_be    <= be_d;
`endif
            if (accept) begin
                byte_q  <= req_op[1];
                lane_q  <= req_addr[1:0];
                wbyte_q <= req_wdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan cases plus random
// traffic against a transaction-level memory model.
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [3:0]  be_obs;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifdef LSU_BYTE_STROBE_EN
    logic [3:0] mem_be;
    assign be_obs = mem_be;
    localparam bit STROBE = 1'b1;
`else
    assign be_obs = 4'hF;
    localparam bit STROBE = 1'b0;
`endif

    lsu_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
`ifdef LSU_BYTE_STROBE_EN
        .mem_be    (mem_be),
`endif
        .mem_rdata (mem_rdata)
    );

    // Data RAM seen by the DUT, plus a bench-side preload port.
    logic [31:0] ram [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          wr_count = 0;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) begin
                wr_count <= wr_count + 1;
`ifdef LSU_BYTE_STROBE_EN
                for (int b = 0; b < 4; b++)
                    if (mem_be[b])
                        ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
                ram[mem_addr] <= mem_wdata;
`endif
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    logic [31:0] ref_mem [0:1023];

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = 10'(w);
        pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issues one request and records what the DUT does until rsp_valid.
    // Cycle numbers count from 1 = first cycle after the accept edge.
    task automatic run_txn(
        input  logic [1:0]  op,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          lat,
        output int          en_n,
        output int          en_first,
        output int          wr_lat,
        output logic        err,
        output logic [31:0] rd,
        output logic [9:0]  en_addr,
        output logic [31:0] wr_data,
        output logic [3:0]  wr_be,
        output logic        busy_ok
    );
        int w;
        lat = -1; en_n = 0; en_first = -1; wr_lat = -1;
        err = 1'b0; rd = '0; en_addr = '0;
        wr_data = '0; wr_be = '0; busy_ok = 1'b1;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                en_addr = mem_addr;
                if (en_first < 0) en_first = c;
            end
            if (mem_en && mem_we) begin
                wr_lat  = c;
                wr_data = mem_wdata;
                wr_be   = be_obs;
            end
            if (req_ready) busy_ok = 1'b0;
            if (!rsp_valid && rsp_rdata !== 32'h0) busy_ok = 1'b0;
            if (rsp_valid) begin
                lat = c;
                err = rsp_err;
                rd  = rsp_rdata;
                break;
            end
        end
    endtask

    // Transaction-level reference: expected outcome from the op rules.
    function automatic void ref_apply(
        input  logic [1:0]  op,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output logic        e_err,
        output logic [31:0] e_rd,
        output int          e_lat,
        output int          e_en,
        output logic [31:0] e_wd,
        output logic [3:0]  e_be
    );
        int          wi;
        int          ln;
        logic [31:0] nw;
        wi = int'((addr >> 2) % 1024);
        ln = int'(addr % 4);
        e_err = 1'b0; e_rd = '0; e_wd = '0; e_be = '0;
        if (!op[1] && ln != 0) begin
            e_err = 1'b1; e_lat = 1; e_en = 0;
            return;
        end
        if (!op[0]) begin
            e_lat = 2; e_en = 1;
            e_rd = op[1] ? ((ref_mem[wi] >> (8*ln)) & 32'hFF) : ref_mem[wi];
        end else if (!op[1]) begin
            e_lat = 1; e_en = 1; e_wd = wd; e_be = 4'hF;
            ref_mem[wi] = wd;
        end else begin
            nw = (ref_mem[wi] & ~(32'hFF << (8*ln))) |
                 (32'(wd[7:0]) << (8*ln));
            if (STROBE) begin
                e_lat = 1; e_en = 1;
                e_wd = {4{wd[7:0]}};
                e_be = 4'(1 << ln);
            end else begin
                e_lat = 3; e_en = 2; e_wd = nw; e_be = 4'hF;
            end
            ref_mem[wi] = nw;
        end
    endfunction

    int          lat, en_n, en_first, wr_lat;
    logic        err, busy_ok;
    logic [31:0] rd, wr_data;
    logic [9:0]  en_addr;
    logic [3:0]  wr_be;

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {req_ready, rsp_valid, rsp_err, mem_en, mem_we});
        end
        vectors++;
        if ({rsp_rdata, mem_wdata, mem_addr} !== 74'h0) begin
            miscompares++;
            $display("FAIL reset_data: got rdata=%h wdata=%h addr=%h want 0",
                     rsp_rdata, mem_wdata, mem_addr);
        end
`ifdef LSU_BYTE_STROBE_EN
        vectors++;
        if (mem_be !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_be: got %b want 0000", mem_be);
        end
`endif
        rst = 1'b1;
    endtask

    task automatic test_lw();
        preload(4, 32'hA1B2C3D4);
        run_txn(OP_LW, 32'h10, 32'h0, lat, en_n, en_first, wr_lat, err, rd,
                en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (lat !== 2 || en_first !== 1 || en_n !== 1) begin
            miscompares++;
            $display("FAIL lw_timing: got lat=%0d en@%0d en_n=%0d want 2 1 1",
                     lat, en_first, en_n);
        end
        vectors++;
        if (rd !== 32'hA1B2C3D4 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL lw_data: got %h err=%b want a1b2c3d4 err=0", rd, err);
        end
    endtask

    task automatic test_lbu();
        logic [31:0] addrs [3];
        logic [31:0] exps [3];
        addrs = '{32'h11, 32'h12, 32'h13};
        exps  = '{32'hC3, 32'hB2, 32'hA1};
        for (int i = 0; i < 3; i++) begin
            run_txn(OP_LBU, addrs[i], 32'h0, lat, en_n, en_first, wr_lat, err,
                    rd, en_addr, wr_data, wr_be, busy_ok);
            vectors++;
            if (rd !== exps[i] || lat !== 2 || err !== 1'b0) begin
                miscompares++;
                $display("FAIL lbu_%h: got %h lat=%0d want %h lat=2",
                         addrs[i], rd, lat, exps[i]);
            end
        end
    endtask

    task automatic test_sb();
        run_txn(OP_SB, 32'h12, 32'hFFFFFF5A, lat, en_n, en_first, wr_lat, err,
                rd, en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (STROBE) begin
            if (wr_lat !== 1 || lat !== 1 || wr_be !== 4'b0100 ||
                wr_data !== 32'h5A5A5A5A) begin
                miscompares++;
                $display("FAIL sb_write: got wr@%0d be=%b d=%h want 1 0100 5a5a5a5a",
                         wr_lat, wr_be, wr_data);
            end
        end else begin
            if (wr_lat !== 3 || lat !== 3 || wr_data !== 32'hA15AC3D4) begin
                miscompares++;
                $display("FAIL sb_write: got wr@%0d d=%h want 3 a15ac3d4",
                         wr_lat, wr_data);
            end
        end
        run_txn(OP_LW, 32'h10, 32'h0, lat, en_n, en_first, wr_lat, err, rd,
                en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (rd !== 32'hA15AC3D4) begin
            miscompares++;
            $display("FAIL sb_readback: got %h want a15ac3d4", rd);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SW;
        req_addr  = 32'h08;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_op    = OP_LW;
        req_wdata = $urandom;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, req_ready, mem_en, mem_we} !== 4'b1011 ||
            mem_wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_sw: got v/r/en/we=%b d=%h want 1011 deadbeef",
                     {rsp_valid, req_ready, mem_en, mem_we}, mem_wdata);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_hold: got ready=%b en=%b want 1 0",
                     req_ready, mem_en);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd2) begin
            miscompares++;
            $display("FAIL b2b_rd: got en=%b we=%b addr=%0d want 1 0 2",
                     mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_lw: got v=%b d=%h want 1 deadbeef",
                     rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_misaligned();
        run_txn(OP_LW, 32'h06, 32'h0, lat, en_n, en_first, wr_lat, err, rd,
                en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || en_n !== 0) begin
            miscompares++;
            $display("FAIL mis_lw: got lat=%0d err=%b d=%h en_n=%0d want 1 1 0 0",
                     lat, err, rd, en_n);
        end
        run_txn(OP_SW, 32'h09, 32'h12345678, lat, en_n, en_first, wr_lat, err,
                rd, en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (lat !== 1 || err !== 1'b1 || en_n !== 0) begin
            miscompares++;
            $display("FAIL mis_sw: got lat=%0d err=%b en_n=%0d want 1 1 0",
                     lat, err, en_n);
        end
    endtask

    task automatic test_reset_mid_sb();
        int wc;
        preload(4, 32'h11223344);
        wc = wr_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 32'h11;
        req_wdata = 32'h77;
        if (STROBE) rst = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (!STROBE) begin
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, mem_en, mem_we} !== 5'b10000 ||
            rsp_rdata !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_sb_outs: got r/v/e/en/we=%b a=%h d=%h want 10000 0 0",
                     {req_ready, rsp_valid, rsp_err, mem_en, mem_we},
                     mem_addr, mem_wdata);
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_count !== wc) begin
            miscompares++;
            $display("FAIL rst_sb_nowrite: got %0d writes want 0", wr_count - wc);
        end
        run_txn(OP_LW, 32'h10, 32'h0, lat, en_n, en_first, wr_lat, err, rd,
                en_addr, wr_data, wr_be, busy_ok);
        vectors++;
        if (rd !== 32'h11223344) begin
            miscompares++;
            $display("FAIL rst_sb_word: got %h want 11223344", rd);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] addr, wd, e_rd, e_wd;
        logic [3:0]  e_be;
        logic        e_err;
        int          e_lat, e_en, wi, ln;
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            preload(w, ref_mem[w]);
        end
        for (int n = 0; n < 150; n++) begin
            op   = 2'($urandom);
            wi   = int'($urandom_range(0, 15));
            ln   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
            addr = ($urandom & 32'hFFFF_F000) | 32'(wi << 2) | 32'(ln);
            wd   = $urandom;
            ref_apply(op, addr, wd, e_err, e_rd, e_lat, e_en, e_wd, e_be);
            run_txn(op, addr, wd, lat, en_n, en_first, wr_lat, err, rd,
                    en_addr, wr_data, wr_be, busy_ok);
            vectors++;
            if (lat !== e_lat || err !== e_err || rd !== e_rd ||
                en_n !== e_en || busy_ok !== 1'b1) begin
                miscompares++;
                $display("FAIL rnd_rsp op=%0d a=%h: got lat=%0d err=%b d=%h en=%0d ok=%b want %0d %b %h %0d 1",
                         op, addr, lat, err, rd, en_n, busy_ok,
                         e_lat, e_err, e_rd, e_en);
            end
            if (e_en > 0) begin
                vectors++;
                if (en_addr !== 10'(wi)) begin
                    miscompares++;
                    $display("FAIL rnd_addr a=%h: got %0d want %0d",
                             addr, en_addr, wi);
                end
            end
            if (op[0] && !e_err) begin
                vectors++;
                if (wr_lat !== e_lat || wr_data !== e_wd || wr_be !== e_be) begin
                    miscompares++;
                    $display("FAIL rnd_wr op=%0d a=%h: got @%0d %h be=%b want @%0d %h be=%b",
                             op, addr, wr_lat, wr_data, wr_be, e_lat, e_wd, e_be);
                end
            end
        end
        @(negedge clk);
        for (int w = 0; w < 16; w++) begin
            vectors++;
            if (ram[w] !== ref_mem[w]) begin
                miscompares++;
                $display("FAIL rnd_ram[%0d]: got %h want %h", w, ram[w], ref_mem[w]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lbu();
        test_sb();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_sb();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
